// File: rtl/multi_channel_waveform_gen.sv
// Multi-channel waveform generator: one shared period counter, per-channel
// rise/fall positions, shadowed configuration reloaded at start and at each wrap.
module multi_channel_waveform_gen #(
  parameter int NCH = 3,
  parameter int CW  = 8,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_stop,
  input  logic           i_oneshot,
  input  logic           i_cfg_we,
  input  logic [CHW-1:0] i_cfg_ch,
  input  logic [1:0]     i_cfg_sel,
  input  logic [CW-1:0]  i_cfg_data,
  output logic [NCH-1:0] o_sig,
  output logic [CW-1:0]  o_cnt,
  output logic           o_busy,
  output logic           o_wrap
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;
  logic                 r_mode, w_mode_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [NCH-1:0]       r_sig, w_sig_nxt;
  logic                 w_copy;
  logic                 w_wr_ok;
  logic                 w_wrap;
  logic [CW-1:0]        w_last;

  logic [CW-1:0]        r_sh_rise   [NCH];
  logic [CW-1:0]        r_sh_fall   [NCH];
  logic [CW-1:0]        r_sh_period;
  logic [CW-1:0]        r_act_rise  [NCH];
  logic [CW-1:0]        r_act_fall  [NCH];
  logic [CW-1:0]        r_act_period;
  logic [CW-1:0]        w_sh_rise_nxt [NCH];
  logic [CW-1:0]        w_sh_fall_nxt [NCH];
  logic [CW-1:0]        w_sh_period_nxt;

  // Periods of 0 and 1 both collapse to a single-count period.
  assign w_last = (r_act_period <= CW'(1)) ? CW'(0) : (r_act_period - CW'(1));
  assign w_wrap = (r_state == S_RUN) && (r_cnt == w_last);

  assign w_wr_ok = i_cfg_we && (i_cfg_sel != 2'd3) &&
                   ((i_cfg_sel == 2'd2) || (32'(i_cfg_ch) < 32'(NCH)));

  // Next shadow values; the active copy loads these, so a coinciding write is forwarded.
  always_comb begin
    w_sh_rise_nxt   = r_sh_rise;
    w_sh_fall_nxt   = r_sh_fall;
    w_sh_period_nxt = r_sh_period;
    if (w_wr_ok) begin
      case (i_cfg_sel)
        2'd0: begin
          for (int i = 0; i < NCH; i++) begin
            if (32'(i_cfg_ch) == i) begin
              w_sh_rise_nxt[i] = i_cfg_data;
            end else begin
              w_sh_rise_nxt[i] = r_sh_rise[i];
            end
          end
        end
        2'd1: begin
          for (int i = 0; i < NCH; i++) begin
            if (32'(i_cfg_ch) == i) begin
              w_sh_fall_nxt[i] = i_cfg_data;
            end else begin
              w_sh_fall_nxt[i] = r_sh_fall[i];
            end
          end
        end
        2'd2:    w_sh_period_nxt = i_cfg_data;
        default: w_sh_period_nxt = r_sh_period;
      endcase
    end else begin
      w_sh_period_nxt = r_sh_period;
    end
  end

  // Next-state, counter and channel-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_sig_nxt   = r_sig;
    w_copy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          w_state_nxt = S_RUN;
          w_mode_nxt  = i_oneshot;
          w_cnt_nxt   = CW'(0);
          w_sig_nxt   = '0;
          w_copy      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_copy = w_wrap;
        if (i_stop || (w_wrap && r_mode)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CW'(0);
          w_sig_nxt   = '0;
        end else begin
          w_cnt_nxt = w_wrap ? CW'(0) : (r_cnt + CW'(1));
          // Clear wins over set, so rise == fall keeps the channel low.
          for (int i = 0; i < NCH; i++) begin
            if (r_cnt == r_act_fall[i]) begin
              w_sig_nxt[i] = 1'b0;
            end else if (r_cnt == r_act_rise[i]) begin
              w_sig_nxt[i] = 1'b1;
            end else begin
              w_sig_nxt[i] = r_sig[i];
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CW'(0);
        w_sig_nxt   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and configuration registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode       <= 1'b0;
      r_cnt        <= CW'(0);
      r_sig        <= '0;
      r_sh_period  <= CW'(0);
      r_act_period <= CW'(0);
      for (int i = 0; i < NCH; i++) begin
        r_sh_rise[i]  <= CW'(0);
        r_sh_fall[i]  <= CW'(0);
        r_act_rise[i] <= CW'(0);
        r_act_fall[i] <= CW'(0);
      end
    end else begin
      r_mode      <= w_mode_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sig       <= w_sig_nxt;
      r_sh_period <= w_sh_period_nxt;
      r_sh_rise   <= w_sh_rise_nxt;
      r_sh_fall   <= w_sh_fall_nxt;
      if (w_copy) begin
        r_act_period <= w_sh_period_nxt;
        r_act_rise   <= w_sh_rise_nxt;
        r_act_fall   <= w_sh_fall_nxt;
      end
    end
  end

  assign o_sig  = r_sig;
  assign o_cnt  = r_cnt;
  assign o_busy = (r_state == S_RUN);
  assign o_wrap = w_wrap;

endmodule

// File: doc/multi_channel_waveform_gen.md
# multi_channel_waveform_gen

Parametrised, programmable multi-channel waveform generator. NCH output channels share one free-running period counter. Each channel has its own rise and fall positions within the period. Edge positions and the period are runtime-configurable through a write port with shadow registers. Continuous and one-shot modes are supported. The block sits next to the protocol-stimulus blocks and drives control strobes into downstream logic.

## Interface
- NCH, 3: number of output channels (1..16)
- CW, 8: width of counter, period and edge-position fields
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin generation; honoured only in IDLE
- stop  in  1  abort generation; honoured in RUN
- oneshot  in  1  sampled with start: 1 = single period, 0 = continuous
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  $clog2(NCH) (min 1)  target channel for rise/fall writes
- cfg_sel  in  2  0 = rise, 1 = fall, 2 = period (cfg_ch ignored), 3 = reserved (write ignored)
- cfg_data  in  CW  value written
- sig  out  NCH  registered waveform outputs
- cnt  out  CW  current counter value
- busy  out  1  high in RUN
- wrap  out  1  high in RUN when cnt equals the last count of the period

## Operation
- States: IDLE, RUN. Reset puts the block in IDLE.
- Reset values:
  - sig = 0, cnt = 0, busy = 0, wrap = 0.
  - Shadow and active rise, fall and period registers = 0.
  - Stored mode = continuous.
- Configuration writes:
  - A cfg_we write updates the shadow register only.
  - A write with cfg_ch >= NCH or cfg_sel = 3 is ignored.
- Shadow-to-active copy:
  - All shadows are copied to the active registers on start acceptance and on every wrap edge.
  - A write on the same edge as a copy is forwarded, so the new value is loaded into active.
- Period handling:
  - last = active_period − 1.
  - active_period of 0 or 1 gives last = 0, so the counter holds 0 and wrap is high every RUN cycle.
- IDLE → RUN:
  - On start = 1 and stop = 0: cnt ← 0, sig ← 0, mode ← oneshot.
- RUN, counter:
  - cnt ← 0 when cnt == last; otherwise cnt ← cnt + 1.
- RUN, per channel i, evaluated on the registered cnt each edge:
  - cnt == fall[i] → sig[i] ← 0 (clear has priority).
  - Otherwise cnt == rise[i] → sig[i] ← 1.
  - Otherwise sig[i] holds. sig holds across a wrap.
  - rise == fall → the channel stays 0.
  - A position > last never matches.
- RUN → IDLE, one-shot: on the wrap edge, cnt ← 0 and sig ← 0.
- RUN → IDLE, stop: next edge, cnt ← 0 and sig ← 0.
- stop and start together in IDLE: stop wins and the block stays in IDLE.
- start in RUN is ignored.
- rst mid-RUN: next edge restores all reset values, including the shadows.
- Arithmetic: the counter is CW bits wide and unsigned. No value outside 0..last is ever produced.

## Timing
- Start accepted at edge E: busy = 1 and cnt = 0 in the cycle after E.
- Output latency: sig[i] is 1 in the cycle after the cycle with cnt == rise[i]. It is 0 in the cycle after cnt == fall[i]. High time = (fall − rise) mod active_period cycles.
- wrap is a decode of registered state and is valid in the same cycle as cnt == last.
- Config takes effect:
  - In IDLE: at the next start.
  - In RUN: in the cycle after the next wrap.
- Stop or one-shot end: busy = 0 one cycle after the terminating edge.

## Test plan
- Basic continuous run (NCH = 3, CW = 8).
  - Stimulus: period = 8; ch0 rise 2 / fall 5; ch1 rise 3 / fall 4; ch2 rise 3 / fall 4; continuous start.
  - Required: sig0 high for cnt 3..5; sig1 and sig2 high for cnt 4 only; pattern repeats every 8 cycles; wrap high at cnt = 7.
- Wrap-around edge.
  - Stimulus: period = 8, rise = 6, fall = 1.
  - Required: first period low until cnt = 7; thereafter high for cnt 7, 0, 1 and low from cnt = 2.
- Degenerate positions.
  - Stimulus: rise = fall = 3, plus a second channel with rise = 9 and period = 8.
  - Required: both channels stay 0 for 4 periods.
- One-shot.
  - Stimulus: period = 5, rise = 1, fall = 4, oneshot = 1.
  - Required: sig high for cnt 2..4; busy drops 1 cycle after cnt = 4; sig = 0; a further start restarts cleanly.
- Live reconfiguration.
  - Stimulus: in RUN with period = 8, write period = 4 and rise = 0 mid-period.
  - Required: current period completes unchanged; the next period wraps at cnt = 3. A write coinciding with wrap takes effect immediately.
- Control corners.
  - start + stop together in IDLE → stays IDLE.
  - stop at cnt = 5 → cnt = 0, sig = 0, busy = 0 the next cycle.
  - rst mid-RUN → all outputs 0; shadows cleared.
  - Period 0 → wrap high every cycle, cnt stuck at 0.
